updown_counter_param: RTL
=========================

// Module: updown_counter_param
// PURPOSE
//   Parametrised synchronous up/down counter with modulus, parallel load, count enable
//   and wrap/saturate mode. Generalises the fixed 4-bit down counter.
//   Used as the shared count/timer primitive for datapath sequencing and lab timers.
//   Provides a terminal-count flag for cascading and a registered wrap pulse.
// PARAMETERS
//   WIDTH      4    counter width in bits, 1..32
//   MODULUS    16   count range 0..MODULUS-1; 2 <= MODULUS <= 2**WIDTH
//   SATURATE   0    0 = wrap at the ends; 1 = hold at the ends
//   RESET_VAL  0    value of q after reset; must be < MODULUS
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous, active-low reset (0 = reset asserted)
//   en        in   1      count enable; one step per clk while high
//   up        in   1      direction: 1 = increment, 0 = decrement
//   load      in   1      synchronous parallel load strobe
//   load_val  in   WIDTH  value captured on load
//   q         out  WIDTH  current count (registered)
//   tc        out  1      terminal count (combinational, see below)
//   wrapped   out  1      one-cycle registered pulse after a wrap event
//   sat       out  1      registered level: high while held at an end in saturate mode
// BEHAVIOUR
//   Reset: while reset == 0 (asynchronous), q = RESET_VAL, wrapped = 0, sat = 0.
//     On release, counting resumes from the first clk edge after reset returns to 1.
//   MAX = MODULUS-1. Priority at each clk edge: load > en > hold.
//   Load: q <= (load_val > MAX) ? MAX : load_val. Clamped, never out of range.
//     A load never asserts wrapped; sat <= 0. Load in the same cycle as en: load wins.
//   Count (en = 1, load = 0):
//     up = 1, q <  MAX: q <= q+1.
//     up = 1, q == MAX: if SATURATE = 0, q <= 0 and wrapped <= 1;
//       if SATURATE = 1, q holds and sat <= 1.
//     up = 0, q >  0:   q <= q-1.
//     up = 0, q == 0:   if SATURATE = 0, q <= MAX and wrapped <= 1;
//       if SATURATE = 1, q holds and sat <= 1.
//     Any step that moves q clears sat.
//   Idle (en = 0, load = 0): q holds; wrapped <= 0; sat holds.
//   wrapped: high exactly one cycle, the cycle after the edge that wrapped.
//     It deasserts on the next edge unless another wrap occurs (MODULUS = 2 can pulse
//     on consecutive cycles).
//   tc = en & ~load & ((up & q==MAX) | (~up & q==0)).
//     Combinational, zero latency; intended as en of a cascaded stage.
//     SATURATE does not affect tc.
//   Direction may change on any cycle; it takes effect on the next edge.
//     No extra latency; no glitch on q.
//   Latency: load/count -> q is 1 cycle. No internal pipeline.
//   All arithmetic is on WIDTH bits; q never exceeds MAX, including MODULUS < 2**WIDTH.
//   Reset mid-count forces RESET_VAL immediately, independent of clk;
//     a pending wrapped pulse is cleared.
// TESTING
//   T1 default params: reset=0 then release; en=1, up=0 for 17 clks
//     -> q = 0,15,14..1,0,15; wrapped high one cycle after each 0->15 step.
//   T2 MODULUS=10: up=1, en=1 from 0
//     -> q = 0..9,0; tc=1 only while q=9; wrapped pulses after the 9->0 step.
//   T3 SATURATE=1, MODULUS=10: load 9, up=1, en=1 for 3 clks
//     -> q stays 9; sat=1 from the 1st edge; up=0 next clk gives q=8, sat=0.
//   T4 MODULUS=10: load_val=13 with load=1, en=1 -> q=9 (clamped), wrapped=0.
//     Next: load=0, up=1 -> q=0, wrapped=1.
//   T5 reset=0 asserted mid-cycle with q=7 and no clk edge
//     -> q=RESET_VAL, wrapped=0, sat=0 immediately; holds until reset=1 and next edge.
//   T6 two instances cascaded, each WIDTH=4, MODULUS=10; hi.en = lo.tc
//     -> counts 00..99 in BCD and rolls to 00; same check in the down direction.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down modulus counter with clamped parallel load, count enable,
// wrap or saturate at the ends, combinational terminal count and registered wrap/sat flags.
module updown_counter_param #(
    parameter int unsigned     WIDTH     = 4,
    parameter longint unsigned MODULUS   = 16,
    parameter bit              SATURATE  = 1'b0,
    parameter longint unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrapped,
    output logic             sat
);

    // MODULUS is 64-bit so WIDTH = 32 with MODULUS = 2**32 stays representable.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] RST = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_wrapped;
    logic             r_sat;

    logic             w_at_end;
    logic [WIDTH-1:0] w_load_clamped;
    logic [WIDTH-1:0] w_step_val;
    logic [WIDTH-1:0] w_wrap_val;

    always_comb begin
        w_at_end       = up ? (r_q == MAX) : (r_q == '0);
        w_load_clamped = (load_val > MAX) ? MAX : load_val;
        w_step_val     = up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
        w_wrap_val     = up ? '0 : MAX;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q       <= RST;
            r_wrapped <= 1'b0;
            r_sat     <= 1'b0;
        end else if (load) begin
            r_q       <= w_load_clamped;
            r_wrapped <= 1'b0;
            r_sat     <= 1'b0;
        end else if (en) begin
            if (!w_at_end) begin
                r_q       <= w_step_val;
                r_wrapped <= 1'b0;
                r_sat     <= 1'b0;
            end else if (SATURATE) begin
                r_wrapped <= 1'b0;
                r_sat     <= 1'b1;
            end else begin
                r_q       <= w_wrap_val;
                r_wrapped <= 1'b1;
                r_sat     <= 1'b0;
            end
        end else begin
            r_wrapped <= 1'b0;
        end
    end

    assign q       = r_q;
    assign wrapped = r_wrapped;
    assign sat     = r_sat;
    assign tc      = en & ~load & w_at_end;

endmodule
